f_fetch_unit: RTL and testbench

//  F-stage instruction fetch unit; producer side of the F->D interface.

---
 rtl/f_fetch_unit_if.sv | 26 ++
 rtl/f_fetch_unit.sv | 125 ++++++++++++
 tb/tb_f_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/f_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface f_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/f_fetch_unit.sv
// F-stage fetch unit: owns the PC, keeps one imem request outstanding and holds
// the returned instruction for the D stage until it is accepted or redirected away.
module f_fetch_unit #(
    parameter logic [31:0] BOOT_PC = 32'h8000_0000,
    parameter int unsigned PC_STEP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    f_fetch_unit_if.master       imem,
    output logic                 F_valid,
    output logic [31:0]          F_instr,
    output logic [31:0]          F_pc,
    output logic                 F_adel
);
    localparam int unsigned XLEN = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HAVE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            valid_d, adel_d;
    logic [XLEN-1:0] instr_d, fpc_d;
    logic            pc_aligned;

    assign pc_aligned     = (pc_q[1:0] == 2'b00);
    // Misaligned PCs never reach imem; the request is suppressed and F_adel raised instead.
    assign imem.imem_req  = (state_q == S_REQ) && pc_aligned;
    assign imem.imem_addr = pc_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= BOOT_PC;
            kill_q  <= 1'b0;
            F_valid <= 1'b0;
            F_instr <= '0;
            F_pc    <= BOOT_PC;
            F_adel  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            F_valid <= valid_d;
            F_instr <= instr_d;
            F_pc    <= fpc_d;
            F_adel  <= adel_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        valid_d = F_valid;
        instr_d = F_instr;
        fpc_d   = F_pc;
        adel_d  = F_adel;

        case (state_q)
            S_IDLE: begin
                if (redirect) pc_d = redirect_pc;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    // A handshake this cycle leaves a response in flight that must be dropped.
                    pc_d = redirect_pc;
                    if (imem.imem_req && imem.imem_ready) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (!pc_aligned) begin
                    valid_d = 1'b1;
                    adel_d  = 1'b1;
                    instr_d = '0;
                    fpc_d   = pc_q;
                    state_d = S_HAVE;
                end else if (imem.imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (redirect || kill_q) begin
                        if (redirect) pc_d = redirect_pc;
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        valid_d = 1'b1;
                        adel_d  = 1'b0;
                        instr_d = imem.imem_rdata;
                        fpc_d   = pc_q;
                        state_d = S_HAVE;
                    end
                end else if (redirect) begin
                    pc_d   = redirect_pc;
                    kill_d = 1'b1;
                end
            end
            S_HAVE: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    adel_d  = 1'b0;
                    state_d = S_REQ;
                end else if (en) begin
                    pc_d    = pc_q + XLEN'(PC_STEP);
                    valid_d = 1'b0;
                    adel_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for f_fetch_unit: drives the imem bus by hand cycle by cycle.
module tb_f_fetch_unit;
    localparam logic [31:0] BOOT = 32'h8000_0000;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        F_valid;
    logic [31:0] F_instr;
    logic [31:0] F_pc;
    logic        F_adel;

    int vec_cnt = 0;
    int err_cnt = 0;
    int hs400   = 0;
    bit stale_seen = 1'b0;

    f_fetch_unit_if imem_bus ();

    f_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus.master),
        .F_valid     (F_valid),
        .F_instr     (F_instr),
        .F_pc        (F_pc),
        .F_adel      (F_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (reset && imem_bus.imem_req && imem_bus.imem_ready && imem_bus.imem_addr == 32'h8000_0400)
            hs400++;

    always @(negedge clk)
        if (F_valid && F_instr == STALE) stale_seen = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #20;
        vec_cnt++; if (imem_bus.imem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
        vec_cnt++; if (imem_bus.imem_addr !== BOOT) begin err_cnt++; $display("FAIL reset_addr: got %h want %h", imem_bus.imem_addr, BOOT); end
        vec_cnt++; if ({F_valid, F_adel} !== 2'b00) begin err_cnt++; $display("FAIL reset_flags: got %b want 00", {F_valid, F_adel}); end
        vec_cnt++; if (F_instr !== 32'h0) begin err_cnt++; $display("FAIL reset_instr: got %h want 0", F_instr); end
        vec_cnt++; if (F_pc !== BOOT) begin err_cnt++; $display("FAIL reset_pc: got %h want %h", F_pc, BOOT); end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        reset = 1'b1;
        imem_bus.imem_ready = 1'b1;
        tick();
        vec_cnt++; if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, BOOT}) begin err_cnt++; $display("FAIL basic_req: got %b/%h want 1/%h", imem_bus.imem_req, imem_bus.imem_addr, BOOT); end
        tick();
        imem_bus.imem_ready = 1'b0;
        vec_cnt++; if (imem_bus.imem_req !== 1'b0) begin err_cnt++; $display("FAIL basic_wait_req: got %b want 0", imem_bus.imem_req); end
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h2402_0001;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        vec_cnt++; if ({F_valid, F_adel, F_pc, F_instr} !== {2'b10, BOOT, 32'h2402_0001}) begin err_cnt++; $display("FAIL basic_have: got v%b a%b %h %h want v1 a0 %h 24020001", F_valid, F_adel, F_pc, F_instr, BOOT); end
        en = 1'b1;
        tick();
        en = 1'b0;
        vec_cnt++; if ({imem_bus.imem_req, imem_bus.imem_addr, F_valid} !== {1'b1, 32'h8000_0004, 1'b0}) begin err_cnt++; $display("FAIL basic_next: got %b/%h v%b want 1/80000004 v0", imem_bus.imem_req, imem_bus.imem_addr, F_valid); end
    endtask

    task automatic test_stall();
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0000_1111;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            imem_bus.imem_rdata = 32'h1357_9BDF ^ (32'h1111_1111 * (i + 1));
            tick();
            vec_cnt++; if ({F_valid, imem_bus.imem_req, F_instr, F_pc} !== {2'b10, 32'h0000_1111, 32'h8000_0004}) begin err_cnt++; $display("FAIL stall_hold[%0d]: got v%b r%b %h %h want v1 r0 00001111 80000004", i, F_valid, imem_bus.imem_req, F_instr, F_pc); end
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        vec_cnt++; if (imem_bus.imem_addr !== 32'h8000_0008) begin err_cnt++; $display("FAIL stall_next: got %h want 80000008", imem_bus.imem_addr); end
    endtask

    task automatic test_redirect_wait();
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect = 1'b0;
        vec_cnt++; if ({imem_bus.imem_req, F_valid} !== 2'b00) begin err_cnt++; $display("FAIL rdw_wait: got r%b v%b want r0 v0", imem_bus.imem_req, F_valid); end
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = STALE;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        vec_cnt++; if ({F_valid, imem_bus.imem_req, imem_bus.imem_addr} !== {2'b01, 32'h8000_0100}) begin err_cnt++; $display("FAIL rdw_drop: got v%b r%b %h want v0 r1 80000100", F_valid, imem_bus.imem_req, imem_bus.imem_addr); end
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0000_0100;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        vec_cnt++; if ({F_valid, F_pc, F_instr} !== {1'b1, 32'h8000_0100, 32'h0000_0100}) begin err_cnt++; $display("FAIL rdw_have: got v%b %h %h want v1 80000100 00000100", F_valid, F_pc, F_instr); end
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic test_redirect_same_cycle();
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = STALE;
        redirect = 1'b1; redirect_pc = 32'h8000_0300;
        tick();
        imem_bus.imem_rvalid = 1'b0; redirect = 1'b0;
        vec_cnt++; if ({F_valid, imem_bus.imem_req, imem_bus.imem_addr} !== {2'b01, 32'h8000_0300}) begin err_cnt++; $display("FAIL same_rvalid: got v%b r%b %h want v0 r1 80000300", F_valid, imem_bus.imem_req, imem_bus.imem_addr); end
        imem_bus.imem_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h8000_0400;
        tick();
        imem_bus.imem_ready = 1'b0; redirect = 1'b0;
        vec_cnt++; if ({imem_bus.imem_req, F_valid} !== 2'b00) begin err_cnt++; $display("FAIL same_ready_wait: got r%b v%b want r0 v0", imem_bus.imem_req, F_valid); end
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = STALE;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        vec_cnt++; if ({F_valid, imem_bus.imem_req, imem_bus.imem_addr} !== {2'b01, 32'h8000_0400}) begin err_cnt++; $display("FAIL same_ready_drop: got v%b r%b %h want v0 r1 80000400", F_valid, imem_bus.imem_req, imem_bus.imem_addr); end
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0000_0400;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        vec_cnt++; if ({F_valid, F_pc, F_instr} !== {1'b1, 32'h8000_0400, 32'h0000_0400}) begin err_cnt++; $display("FAIL same_have: got v%b %h %h want v1 80000400 00000400", F_valid, F_pc, F_instr); end
        tick(); tick();
        imem_bus.imem_ready = 1'b0;
        vec_cnt++; if (hs400 !== 1) begin err_cnt++; $display("FAIL same_fetch_count: got %0d want 1", hs400); end
        vec_cnt++; if (stale_seen !== 1'b0) begin err_cnt++; $display("FAIL stale_visible: got %b want 0", stale_seen); end
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
        redirect = 1'b0;
        imem_bus.imem_ready = 1'b1;
        vec_cnt++; if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b0, 32'h8000_0102}) begin err_cnt++; $display("FAIL adel_req: got %b/%h want 0/80000102", imem_bus.imem_req, imem_bus.imem_addr); end
        tick();
        imem_bus.imem_ready = 1'b0;
        vec_cnt++; if ({F_valid, F_adel, imem_bus.imem_req, F_instr, F_pc} !== {3'b110, 32'h0, 32'h8000_0102}) begin err_cnt++; $display("FAIL adel_have: got v%b a%b r%b %h %h want v1 a1 r0 00000000 80000102", F_valid, F_adel, imem_bus.imem_req, F_instr, F_pc); end
        redirect = 1'b1; redirect_pc = 32'h8000_0200;
        tick();
        redirect = 1'b0;
        vec_cnt++; if ({F_valid, F_adel, imem_bus.imem_req, imem_bus.imem_addr} !== {3'b001, 32'h8000_0200}) begin err_cnt++; $display("FAIL adel_clear: got v%b a%b r%b %h want v0 a0 r1 80000200", F_valid, F_adel, imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h0000_0001;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        vec_cnt++; if ({F_valid, F_pc} !== {1'b1, 32'hFFFF_FFFC}) begin err_cnt++; $display("FAIL wrap_have: got v%b %h want v1 fffffffc", F_valid, F_pc); end
        en = 1'b1;
        tick();
        en = 1'b0;
        vec_cnt++; if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, 32'h0}) begin err_cnt++; $display("FAIL wrap_next: got %b/%h want 1/00000000", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_reset_mid();
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        vec_cnt++; if ({imem_bus.imem_req, F_valid, F_adel, imem_bus.imem_addr, F_pc} !== {3'b000, BOOT, BOOT}) begin err_cnt++; $display("FAIL rstmid_outputs: got r%b v%b a%b %h %h want r0 v0 a0 %h %h", imem_bus.imem_req, F_valid, F_adel, imem_bus.imem_addr, F_pc, BOOT, BOOT); end
        tick();
        reset = 1'b1;
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = STALE;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        vec_cnt++; if ({imem_bus.imem_req, F_valid, imem_bus.imem_addr} !== {2'b10, BOOT}) begin err_cnt++; $display("FAIL rstmid_refetch: got r%b v%b %h want r1 v0 %h", imem_bus.imem_req, F_valid, imem_bus.imem_addr, BOOT); end
        imem_bus.imem_ready = 1'b1;
        tick();
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h2402_0001;
        tick();
        imem_bus.imem_rvalid = 1'b0;
        vec_cnt++; if ({F_valid, F_pc, F_instr} !== {1'b1, BOOT, 32'h2402_0001}) begin err_cnt++; $display("FAIL rstmid_have: got v%b %h %h want v1 %h 24020001", F_valid, F_pc, F_instr, BOOT); end
    endtask

    initial begin
        en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = 32'h0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
